// File: rtl/pe_pkg.sv
// Shared constants and nucleotide encoding for the pe selection array.
// Used by pe and pe_row_mux.
package pe_pkg;

    localparam int NUM_LANES = 16;
    localparam int CODE_W    = 2;
    localparam int ROW_W     = 40;
    localparam int NUM_ROWS  = 4;

    localparam int NUCL_W    = NUM_LANES * CODE_W;
    localparam int MATRIX_W  = NUM_ROWS * ROW_W;

    typedef enum logic [CODE_W-1:0] {
        NUCL_A = 2'd0,
        NUCL_C = 2'd1,
        NUCL_G = 2'd2,
        NUCL_T = 2'd3
    } nucl_e;

endpackage

// File: rtl/pe_row_mux.sv
// One lane of the pe array: a 4:1 multiplexer picking one 40-bit row of the
// scoring matrix by nucleotide code. Purely combinational; rows pass through untouched.
module pe_row_mux
    import pe_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    input  logic [MATRIX_W-1:0] matrix,
    output logic [ROW_W-1:0]    row
);

    always_comb begin
        row = matrix[0 +: ROW_W];
        unique case (nucl_e'(code))
            NUCL_A: row = matrix[0*ROW_W +: ROW_W];
            NUCL_C: row = matrix[1*ROW_W +: ROW_W];
            NUCL_G: row = matrix[2*ROW_W +: ROW_W];
            NUCL_T: row = matrix[3*ROW_W +: ROW_W];
        endcase
    end

endmodule

// File: rtl/pe.sv
// Processing element: 16 parallel lanes, each selecting a matrix_P row by its
// nucleotide code. Macro PE_OUT_REG_EN registers outputs (1-cycle latency, sync reset).
module pe
    import pe_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUCL_W-1:0]   nucl_alig,
    input  logic [MATRIX_W-1:0] matrix_P,
    output logic [ROW_W-1:0]    selected_matrix_0,
    output logic [ROW_W-1:0]    selected_matrix_1,
    output logic [ROW_W-1:0]    selected_matrix_2,
    output logic [ROW_W-1:0]    selected_matrix_3,
    output logic [ROW_W-1:0]    selected_matrix_4,
    output logic [ROW_W-1:0]    selected_matrix_5,
    output logic [ROW_W-1:0]    selected_matrix_6,
    output logic [ROW_W-1:0]    selected_matrix_7,
    output logic [ROW_W-1:0]    selected_matrix_8,
    output logic [ROW_W-1:0]    selected_matrix_9,
    output logic [ROW_W-1:0]    selected_matrix_10,
    output logic [ROW_W-1:0]    selected_matrix_11,
    output logic [ROW_W-1:0]    selected_matrix_12,
    output logic [ROW_W-1:0]    selected_matrix_13,
    output logic [ROW_W-1:0]    selected_matrix_14,
    output logic [ROW_W-1:0]    selected_matrix_15
);

    logic [ROW_W-1:0] lane_row [NUM_LANES];
    logic [ROW_W-1:0] lane_out [NUM_LANES];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pe_row_mux u_row_mux (
            .code   (nucl_alig[i*CODE_W +: CODE_W]),
            .matrix (matrix_P),
            .row    (lane_row[i])
        );
    end

`ifdef PE_OUT_REG_EN
    // Reset wins over the data update on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_out[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_out[i] <= lane_row[i];
            end
        end
    end
`else
    // Combinational build: clk and reset stay on the port list but do nothing.
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_out[i] = lane_row[i];
        end
    end
`endif

    assign selected_matrix_0  = lane_out[0];
    assign selected_matrix_1  = lane_out[1];
    assign selected_matrix_2  = lane_out[2];
    assign selected_matrix_3  = lane_out[3];
    assign selected_matrix_4  = lane_out[4];
    assign selected_matrix_5  = lane_out[5];
    assign selected_matrix_6  = lane_out[6];
    assign selected_matrix_7  = lane_out[7];
    assign selected_matrix_8  = lane_out[8];
    assign selected_matrix_9  = lane_out[9];
    assign selected_matrix_10 = lane_out[10];
    assign selected_matrix_11 = lane_out[11];
    assign selected_matrix_12 = lane_out[12];
    assign selected_matrix_13 = lane_out[13];
    assign selected_matrix_14 = lane_out[14];
    assign selected_matrix_15 = lane_out[15];

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe; works with PE_OUT_REG_EN defined (registered)
// or undefined (combinational).
module tb_pe;

`ifdef PE_OUT_REG_EN
    localparam bit REG_MODE = 1'b1;
`else
    localparam bit REG_MODE = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [31:0]  nucl_alig;
    logic [159:0] matrix_P;
    logic [39:0]  dut_out [16];

    int n_cmp;
    int n_err;
    logic [39:0] prev_exp [16];
    bit have_prev;

    pe dut (
        .clk                (clk),
        .reset              (reset),
        .nucl_alig          (nucl_alig),
        .matrix_P           (matrix_P),
        .selected_matrix_0  (dut_out[0]),
        .selected_matrix_1  (dut_out[1]),
        .selected_matrix_2  (dut_out[2]),
        .selected_matrix_3  (dut_out[3]),
        .selected_matrix_4  (dut_out[4]),
        .selected_matrix_5  (dut_out[5]),
        .selected_matrix_6  (dut_out[6]),
        .selected_matrix_7  (dut_out[7]),
        .selected_matrix_8  (dut_out[8]),
        .selected_matrix_9  (dut_out[9]),
        .selected_matrix_10 (dut_out[10]),
        .selected_matrix_11 (dut_out[11]),
        .selected_matrix_12 (dut_out[12]),
        .selected_matrix_13 (dut_out[13]),
        .selected_matrix_14 (dut_out[14]),
        .selected_matrix_15 (dut_out[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %010h expected %010h", tag, obs, exp);
        end
    endtask

    // Reference: lane i picks row number given by its 2-bit field.
    function automatic logic [39:0] ref_row(input logic [31:0] nucl, input logic [159:0] mat, input int lane);
        int code;
        logic [159:0] shifted;
        code    = int'((nucl >> (2 * lane)) & 32'd3);
        shifted = mat >> (40 * code);
        return shifted[39:0];
    endfunction

    // Drive on negedge, check pre-edge (latency) and post-edge values.
    task automatic apply(input logic [31:0] nucl, input logic [159:0] mat, input logic rst, input string tag);
        logic [39:0] exp;
        @(negedge clk);
        nucl_alig = nucl;
        matrix_P  = mat;
        reset     = rst;
        #1;
        if (have_prev) begin
            for (int i = 0; i < 16; i++) begin
                exp = REG_MODE ? prev_exp[i] : ref_row(nucl, mat, i);
                check_val($sformatf("%s_pre_lane%0d", tag, i), dut_out[i], exp);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            exp = (REG_MODE && !rst) ? 40'h0 : ref_row(nucl, mat, i);
            check_val($sformatf("%s_lane%0d", tag, i), dut_out[i], exp);
            prev_exp[i] = exp;
        end
        have_prev = 1'b1;
    endtask

    function automatic logic [159:0] rand_matrix();
        logic [159:0] m;
        for (int k = 0; k < 5; k++) m[32*k +: 32] = $urandom;
        return m;
    endfunction

    initial begin
        logic [159:0] mat;
        logic [39:0]  exp;
        n_cmp     = 0;
        n_err     = 0;
        have_prev = 1'b0;
        reset     = 1'b0;
        nucl_alig = '0;
        matrix_P  = '0;

        // Reset with arbitrary inputs.
        apply($urandom, rand_matrix(), 1'b0, "reset");

        // Directed mixed-code pattern.
        mat = 160'h1000000001000000000200000000030000000004;
        apply(32'h001B1B1B, mat, 1'b1, "dir");
        for (int i = 0; i < 16; i++) begin
            case (i)
                0, 4, 8:  exp = 40'h1000000001;
                1, 5, 9:  exp = 40'h0000000002;
                2, 6, 10: exp = 40'h0000000003;
                default:  exp = 40'h0000000004;
            endcase
            check_val($sformatf("dir_const_lane%0d", i), dut_out[i], exp);
        end

        // All-T then all-A with distinct rows.
        mat = {40'hAAAA_BBBB_CC, 40'h1234_5678_9A, 40'hDEAD_BEEF_01, 40'h0F0F_F0F0_55};
        apply(32'hFFFFFFFF, mat, 1'b1, "all_t");
        for (int i = 0; i < 16; i++)
            check_val($sformatf("all_t_const_lane%0d", i), dut_out[i], 40'hAAAA_BBBB_CC);
        apply(32'h00000000, mat, 1'b1, "all_a");
        for (int i = 0; i < 16; i++)
            check_val($sformatf("all_a_const_lane%0d", i), dut_out[i], 40'h0F0F_F0F0_55);

        // Reset on the same edge as a new code, then release.
        apply(32'h5555AAAA, mat, 1'b0, "rst_same_edge");
        apply(32'h5555AAAA, mat, 1'b1, "rst_release");

        // Random traffic, occasional reset.
        for (int c = 0; c < 1000; c++) begin
            apply($urandom, rand_matrix(), ($urandom_range(0, 31) != 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
